capture_buffer: RTL and testbench

- Sample-capture stage directly downstream of the trigger system.
- Continuously records the 16-bit probe port into a circular RAM while armed, holding a programmable number of pre-trigger samples.
- On the trigger's rising edge, records a programmable number of post-trigger samples, then freezes.
- Streams the frozen window out oldest-first over a valid/ready interface to the host link.
- Shares the trigger system's command/config bus.

---
 rtl/capture_pkg.sv | 27 ++
 rtl/capture_buffer_if.sv | 16 +
 rtl/capture_ram.sv | 25 ++
 rtl/capture_buffer.sv | 207 ++++++++++++++++++++
 tb/tb_capture_buffer.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/capture_pkg.sv
// capture_pkg
// Shared definitions for the capture buffer. Holds the capture FSM state
// type, the command map shared with the trigger system, and a small
// clamping helper.
package capture_pkg;

  typedef enum logic [2:0] {
    CAP_IDLE      = 3'd0,
    CAP_FILL      = 3'd1,
    CAP_WAIT_TRIG = 3'd2,
    CAP_POST      = 3'd3,
    CAP_DONE      = 3'd4,
    CAP_READOUT   = 3'd5
  } cap_state_t;

  // Trigger and capture blocks decode the same command bus.
  localparam logic [7:0] CMD_TRIG_RUN     = 8'd0;
  localparam logic [7:0] CMD_TRIG_HALT    = 8'd1;
  localparam logic [7:0] CMD_CAP_SET_PRE  = 8'd10;
  localparam logic [7:0] CMD_CAP_SET_POST = 8'd11;
  localparam logic [7:0] CMD_CAP_READ     = 8'd12;

  function automatic logic [16:0] min17(input logic [16:0] a, input logic [16:0] b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/capture_buffer_if.sv
// capture_buffer_if
// Readout stream from the capture buffer to the host link.
//   rd_valid : sample on rd_data is valid
//   rd_ready : consumer accepts the sample this cycle
//   rd_data  : readout sample
// master = capture buffer (source), slave = host link (sink).
interface capture_buffer_if #(
  parameter int WIDTH = 16
);
  logic             rd_valid;
  logic             rd_ready;
  logic [WIDTH-1:0] rd_data;

  modport master (output rd_valid, output rd_data, input rd_ready);
  modport slave  (input rd_valid, input rd_data, output rd_ready);
endinterface

// File: rtl/capture_ram.sv
// capture_ram
// Simple dual-port sample RAM, 2**DEPTH_LOG2 x WIDTH. One write port and
// one registered read port (rdata valid the cycle after raddr). No reset so
// it maps onto block RAM.
//   inclk        : clock
//   we/waddr/wdata : write port
//   raddr/rdata  : read port, one cycle latency
module capture_ram #(
  parameter int DEPTH_LOG2 = 12,
  parameter int WIDTH      = 16
) (
  input  logic                  inclk,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] waddr,
  input  logic [WIDTH-1:0]      wdata,
  input  logic [DEPTH_LOG2-1:0] raddr,
  output logic [WIDTH-1:0]      rdata
);
  logic [WIDTH-1:0] mem [2**DEPTH_LOG2];

  always_ff @(posedge inclk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end
endmodule

// File: rtl/capture_buffer.sv
// capture_buffer
// Circular pre/post-trigger sample capture. While armed, inport is written
// into the RAM every cycle; a rising edge on trig starts the post-trigger
// count, after which the window freezes and can be streamed out
// oldest-first.
//   inclk, rst_n    : clock, async active-low reset
//   command/config_in : shared command/config bus
//   inport          : probe samples
//   trig            : trigger level (sticky)
//   rd              : readout stream (master)
//   done            : window frozen (DONE or READOUT)
//   cap_state       : FSM state
//   cap_count       : samples in the frozen window
module capture_buffer
  import capture_pkg::*;
#(
  parameter int DEPTH_LOG2 = 12,
  parameter int WIDTH      = 16
) (
  input  logic                  inclk,
  input  logic                  rst_n,
  input  logic [7:0]            command,
  input  logic [23:0]           config_in,
  input  logic [WIDTH-1:0]      inport,
  input  logic                  trig,
  capture_buffer_if.master      rd,
  output logic                  done,
  output logic [2:0]            cap_state,
  output logic [DEPTH_LOG2:0]   cap_count
);
  localparam int DEPTH = 2**DEPTH_LOG2;
  localparam int AW    = DEPTH_LOG2;
  localparam int CW    = DEPTH_LOG2 + 1;

  cap_state_t state, state_nxt;

  logic          trig_q, trig_evt;
  logic          cmd_run, cmd_halt, cmd_read, cmd_pre, cmd_post, cfg_ok;
  logic [15:0]   pre_cfg, post_cfg;
  logic [16:0]   pre_c, post_c;
  logic [AW-1:0] wptr, filled, eff_pre, start, rptr, pv;
  logic [CW-1:0] eff_post, post_cnt, issued, xfer;
  logic          fill_done, post_last, we;

  // readout pipe: rq_vld = RAM read in flight, out reg + one-entry skid
  logic             rq_vld, rd_valid_q, sk_vld, pop, rd_last, issue;
  logic [1:0]       occ;
  logic [WIDTH-1:0] ram_rdata, rd_data_q, sk_data;
  logic             unused_bits;

  assign unused_bits = ^{config_in[7:0], pre_c[16:AW], post_c[16:CW]};

  assign trig_evt = trig & ~trig_q;
  assign cfg_ok   = (state == CAP_IDLE) || (state == CAP_DONE);
  assign cmd_run  = (command == CMD_TRIG_RUN);
  assign cmd_halt = (command == CMD_TRIG_HALT);
  assign cmd_read = (command == CMD_CAP_READ);
  assign cmd_pre  = (command == CMD_CAP_SET_PRE)  && cfg_ok;
  assign cmd_post = (command == CMD_CAP_SET_POST) && cfg_ok;

  // Window limits latched at arm time; post is limited so pre+post fits.
  always_comb begin
    pre_c  = min17({1'b0, pre_cfg}, 17'(DEPTH - 1));
    post_c = min17({1'b0, post_cfg}, 17'(DEPTH) - pre_c);
    if (post_c == '0) post_c = 17'd1;
  end

  assign fill_done = (CW'(filled) + CW'(1)) >= CW'(eff_pre);
  assign post_last = (post_cnt + CW'(1)) == eff_post;
  assign pv        = (state == CAP_FILL) ? filled : eff_pre;

  assign pop     = rd_valid_q & rd.rd_ready;
  assign rd_last = pop && ((xfer + CW'(1)) == cap_count);
  assign occ     = 2'(rd_valid_q) + 2'(sk_vld) + 2'(rq_vld);
  // Only issue a read if out reg + skid can absorb it after this cycle's pop.
  assign issue   = (state == CAP_READOUT) && (issued != cap_count) &&
                   ((occ - 2'(pop)) < 2'd2);

  // FSM: state register
  always_ff @(posedge inclk or negedge rst_n) begin
    if (!rst_n) state <= CAP_IDLE;
    else        state <= state_nxt;
  end

  // FSM: next state
  always_comb begin
    state_nxt = state;
    if (cmd_halt) state_nxt = CAP_IDLE;
    else begin
      case (state)
        CAP_IDLE:      if (cmd_run) state_nxt = CAP_FILL;
        CAP_FILL:      if (trig_evt) state_nxt = (eff_post == CW'(1)) ? CAP_DONE : CAP_POST;
                       else if (fill_done) state_nxt = CAP_WAIT_TRIG;
        CAP_WAIT_TRIG: if (trig_evt) state_nxt = (eff_post == CW'(1)) ? CAP_DONE : CAP_POST;
        CAP_POST:      if (post_last) state_nxt = CAP_DONE;
        CAP_DONE:      if (cmd_read) state_nxt = CAP_READOUT;
        CAP_READOUT:   if (rd_last) state_nxt = CAP_IDLE;
        default:       state_nxt = CAP_IDLE;
      endcase
    end
  end

  // FSM: outputs
  always_comb begin
    done      = 1'b0;
    we        = 1'b0;
    cap_state = state;
    case (state)
      CAP_FILL, CAP_WAIT_TRIG, CAP_POST: we   = 1'b1;
      CAP_DONE, CAP_READOUT:             done = 1'b1;
      default: ;
    endcase
  end

  // Capture datapath
  always_ff @(posedge inclk or negedge rst_n) begin
    if (!rst_n) begin
      trig_q    <= 1'b0;
      pre_cfg   <= '0;
      post_cfg  <= 16'd1;
      wptr      <= '0;
      filled    <= '0;
      eff_pre   <= '0;
      eff_post  <= CW'(1);
      post_cnt  <= '0;
      start     <= '0;
      cap_count <= '0;
    end else begin
      trig_q <= trig;
      if (cmd_pre)  pre_cfg  <= config_in[23:8];
      if (cmd_post) post_cfg <= config_in[23:8];
      if (state == CAP_IDLE && cmd_run) begin
        wptr     <= '0;
        filled   <= '0;
        eff_pre  <= pre_c[AW-1:0];
        eff_post <= post_c[CW-1:0];
      end
      if (we) wptr <= wptr + AW'(1);
      if (state == CAP_FILL) filled <= filled + AW'(1);
      // The sample written on the trigger cycle is post sample 1.
      if ((state == CAP_FILL || state == CAP_WAIT_TRIG) && trig_evt) begin
        post_cnt  <= CW'(1);
        start     <= wptr - pv;
        cap_count <= CW'(pv) + eff_post;
      end
      if (state == CAP_POST) post_cnt <= post_cnt + CW'(1);
    end
  end

  // Readout datapath
  always_ff @(posedge inclk or negedge rst_n) begin
    if (!rst_n) begin
      rptr       <= '0;
      issued     <= '0;
      xfer       <= '0;
      rq_vld     <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      sk_vld     <= 1'b0;
      sk_data    <= '0;
    end else if (cmd_halt || state != CAP_READOUT) begin
      rq_vld     <= 1'b0;
      rd_valid_q <= 1'b0;
      sk_vld     <= 1'b0;
      if (state == CAP_DONE && cmd_read) begin
        rptr   <= start;
        issued <= '0;
        xfer   <= '0;
      end
    end else begin
      rq_vld <= issue;
      if (issue) begin
        rptr   <= rptr + AW'(1);
        issued <= issued + CW'(1);
      end
      if (pop) xfer <= xfer + CW'(1);
      if (pop || !rd_valid_q) begin
        if (sk_vld) begin
          rd_data_q  <= sk_data;
          rd_valid_q <= 1'b1;
          sk_vld     <= rq_vld;
          sk_data    <= ram_rdata;
        end else if (rq_vld) begin
          rd_data_q  <= ram_rdata;
          rd_valid_q <= 1'b1;
        end else begin
          rd_valid_q <= 1'b0;
        end
      end else if (rq_vld) begin
        sk_data <= ram_rdata;
        sk_vld  <= 1'b1;
      end
    end
  end

  assign rd.rd_valid = rd_valid_q;
  assign rd.rd_data  = rd_data_q;

  capture_ram #(.DEPTH_LOG2(DEPTH_LOG2), .WIDTH(WIDTH)) u_ram (
    .inclk (inclk),
    .we    (we),
    .waddr (wptr),
    .wdata (inport),
    .raddr (rptr),
    .rdata (ram_rdata)
  );
endmodule

// File: tb/tb_capture_buffer.sv
// tb_capture_buffer
// Directed + randomized checks of capture_buffer at DEPTH=16. inport is a
// free-running counter cleared on arm, so a captured window is a run of
// consecutive values ending eff_post-1 after the trigger sample.
module tb_capture_buffer;
  import capture_pkg::*;

  localparam int DL    = 4;
  localparam int W     = 16;
  localparam int DEPTH = 16;
  localparam logic [7:0] NOP = 8'd5;

  logic          inclk = 1'b0;
  logic          rst_n = 1'b0;
  logic          trig = 1'b0;
  logic          cnt_clr = 1'b0;
  logic [7:0]    command = NOP;
  logic [23:0]   config_in = '0;
  logic [W-1:0]  cnt;
  logic          done;
  logic [2:0]    cap_state;
  logic [DL:0]   cap_count;

  int checks = 0;
  int errors = 0;
  int exp_count, exp_first;

  capture_buffer_if #(.WIDTH(W)) rdif ();

  capture_buffer #(.DEPTH_LOG2(DL), .WIDTH(W)) dut (
    .inclk     (inclk),
    .rst_n     (rst_n),
    .command   (command),
    .config_in (config_in),
    .inport    (cnt),
    .trig      (trig),
    .rd        (rdif),
    .done      (done),
    .cap_state (cap_state),
    .cap_count (cap_count)
  );

  always #5 inclk = ~inclk;

  always @(posedge inclk or negedge rst_n) begin
    if (!rst_n)       cnt <= '0;
    else if (cnt_clr) cnt <= '0;
    else              cnt <= cnt + 16'd1;
  end

  task automatic step();
    @(posedge inclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] c, input logic [15:0] v);
    command   = c;
    config_in = {v, 8'h00};
    step();
    command   = NOP;
  endtask

  // Arm with counter cleared, raise trig when the counter shows tval,
  // wait for the frozen window. Reference window from clamp rules.
  task automatic arm(input int pre, input int post, input int tval, input bit do_cfg);
    int ep, eo, pvl, n;
    if (do_cfg) begin
      send(CMD_CAP_SET_PRE, 16'(pre));
      send(CMD_CAP_SET_POST, 16'(post));
    end
    ep = (pre > DEPTH - 1) ? DEPTH - 1 : pre;
    eo = (post > DEPTH - ep) ? DEPTH - ep : post;
    if (eo < 1) eo = 1;
    pvl = (tval < ep) ? tval : ep;
    exp_count = pvl + eo;
    exp_first = tval - pvl;
    command = CMD_TRIG_RUN;
    cnt_clr = 1'b1;
    step();
    command = NOP;
    cnt_clr = 1'b0;
    chk("armed_state", cap_state, 1);
    n = 0;
    while (int'(cnt) != tval && n < 200) begin step(); n++; end
    trig = 1'b1;
    n = 0;
    while (done !== 1'b1 && n < 64) begin step(); n++; end
    chk("done", done, 1);
    chk("cap_count", cap_count, exp_count);
    chk("state_done", cap_state, 4);
    trig = 1'b0;
    step();
  endtask

  // mode 0: ready always, 1: ready pattern 1,0,0,1, 2: random ready
  task automatic readout(input int mode);
    int k, i, first;
    logic r, held_v;
    logic [W-1:0] held_d;
    k = 0; i = 0; first = -1; held_v = 1'b0; held_d = '0;
    rdif.rd_ready = 1'b0;
    send(CMD_CAP_READ, 16'd0);
    while (k < exp_count && i < 400) begin
      case (mode)
        0:       r = 1'b1;
        1:       r = (i % 4 == 0) || (i % 4 == 3);
        default: r = 1'($urandom_range(0, 1));
      endcase
      rdif.rd_ready = r;
      if (rdif.rd_valid === 1'b1 && first < 0) begin
        first = i;
        chk("first_latency", (i <= 2), 1);
      end
      if (mode == 0 && first >= 0) chk("throughput", rdif.rd_valid, 1);
      if (held_v) begin
        chk("hold_valid", rdif.rd_valid, 1);
        chk("hold_data", rdif.rd_data, held_d);
      end
      held_v = (rdif.rd_valid === 1'b1) && !r;
      held_d = rdif.rd_data;
      if (rdif.rd_valid === 1'b1 && r) begin
        chk("data", rdif.rd_data, 16'(exp_first + k));
        k++;
      end
      step();
      i++;
    end
    chk("xfers", k, exp_count);
    chk("end_state", cap_state, 0);
    chk("end_valid", rdif.rd_valid, 0);
    chk("end_done", done, 0);
    rdif.rd_ready = 1'b0;
  endtask

  initial begin
    rdif.rd_ready = 1'b0;
    repeat (3) step();
    chk("rst_state", cap_state, 0);
    chk("rst_valid", rdif.rd_valid, 0);
    chk("rst_data", rdif.rd_data, 0);
    chk("rst_done", done, 0);
    chk("rst_count", cap_count, 0);
    rst_n = 1'b1;
    step();

    // default config pre=0 post=1: single-sample window at the trigger
    arm(0, 1, 5, 1'b0);
    readout(0);

    arm(4, 4, 20, 1'b1);
    readout(0);
    arm(4, 4, 2, 1'b1);
    readout(0);
    arm(12, 10, 40, 1'b1);
    readout(0);
    arm(4, 4, 20, 1'b1);
    readout(1);

    // trig already high at arm: no edge, stays waiting; RUN ignored; HALT
    send(CMD_CAP_SET_PRE, 16'd4);
    trig = 1'b1;
    step();
    send(CMD_TRIG_RUN, 16'd0);
    repeat (30) step();
    chk("trig_held_state", cap_state, 2);
    send(CMD_TRIG_RUN, 16'd0);
    chk("run_ignored", cap_state, 2);
    send(CMD_TRIG_HALT, 16'd0);
    chk("halt_state", cap_state, 0);
    chk("halt_done", done, 0);
    trig = 1'b0;
    step();

    // reset during POST
    send(CMD_CAP_SET_PRE, 16'd4);
    send(CMD_CAP_SET_POST, 16'd15);
    command = CMD_TRIG_RUN; cnt_clr = 1'b1;
    step();
    command = NOP; cnt_clr = 1'b0;
    for (int n = 0; n < 100 && cnt != 16'd20; n++) step();
    trig = 1'b1;
    repeat (3) step();
    chk("post_state", cap_state, 3);
    rst_n = 1'b0;
    #1;
    chk("rst_post_state", cap_state, 0);
    chk("rst_post_done", done, 0);
    chk("rst_post_valid", rdif.rd_valid, 0);
    trig = 1'b0;
    step(); step();
    rst_n = 1'b1;
    step();

    // reset during READOUT with consumer stalled
    arm(4, 4, 20, 1'b1);
    rdif.rd_ready = 1'b0;
    send(CMD_CAP_READ, 16'd0);
    repeat (3) step();
    chk("ro_state", cap_state, 5);
    chk("ro_valid", rdif.rd_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("rst_ro_state", cap_state, 0);
    chk("rst_ro_valid", rdif.rd_valid, 0);
    chk("rst_ro_done", done, 0);
    step(); step();
    rst_n = 1'b1;
    step();
    arm(4, 4, 20, 1'b1);
    readout(0);

    // randomized windows, including over-range config values
    for (int t = 0; t < 8; t++) begin
      arm(int'($urandom_range(0, 20)), int'($urandom_range(0, 20)),
          int'($urandom_range(0, 40)), 1'b1);
      readout(int'($urandom_range(0, 2)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
